// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg
//   Shared types and constants for the LFSR random-byte buffer:
//   FSM state encoding, sample byte width, default parameter values
//   and the sample whitening helper.
package lfsr_rng_pkg;

   localparam int SAMPLE_W        = 8;
   localparam int DEPTH_DEF       = 8;
   localparam int STUCK_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // Folds two bytes of the LFSR state into one output byte.
   function automatic logic [SAMPLE_W-1:0] sample_byte(input logic [SAMPLE_W-1:0] lo,
                                                        input logic [SAMPLE_W-1:0] hi);
      return lo ^ hi;
   endfunction

endpackage

// File: rtl/lfsr_rng_buffer_if.sv
// lfsr_rng_buffer_if
//   Read-side valid/ready handshake of the random-byte buffer.
//   rd_valid : buffer holds at least one byte
//   rd_data  : byte at the head of the buffer
//   rd_ready : consumer accepts the head byte this cycle
//   master = the buffer (producer), slave = the consumer.
interface lfsr_rng_buffer_if;
   import lfsr_rng_pkg::*;

   logic                rd_valid;
   logic [SAMPLE_W-1:0] rd_data;
   logic                rd_ready;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/lfsr_rng_buffer_fifo.sv
// rng_fifo
//   Byte FIFO with occupancy count, synchronous flush and simultaneous
//   push/pop when full.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : synchronous flush, wins over push/pop
//   push_i     : write data_i (ignored when full unless popping too)
//   pop_i      : remove head byte (ignored when empty)
//   data_o     : head byte, forced to 0 while empty
//   full_o, empty_o, count_o : occupancy status
module rng_fifo
   import lfsr_rng_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [SAMPLE_W-1:0]   data_i,
   input  logic                  pop_i,
   output logic [SAMPLE_W-1:0]   data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [SAMPLE_W-1:0] mem_q [DEPTH];
   logic [SAMPLE_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                do_push_s, do_pop_s;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == {CW{1'b0}});
   assign count_o = count_q;
   // Gate the head so stale storage never leaks out while empty.
   assign data_o  = empty_o ? {SAMPLE_W{1'b0}} : mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      do_pop_s  = pop_i && !empty_o;
      // A full FIFO still accepts a byte when the head leaves in the same cycle.
      do_push_s = push_i && (!full_o || do_pop_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (clear_i) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {SAMPLE_W{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/lfsr_rng_buffer.sv
// lfsr_rng_buffer
//   Samples a free-running upstream LFSR into a byte FIFO and watches the
//   LFSR for a stuck source (all-zero state or repeated state).
//   clk, rst_n   : clock, async active-low reset
//   lfsr_state_i : upstream LFSR state, new value each cycle
//   enable_i     : sampling enable
//   clear_i      : synchronous flush of FIFO, flags and stuck counter
//   bus          : read handshake (rd_valid / rd_data / rd_ready)
//   count_o      : FIFO occupancy
//   overflow_o   : sticky, a sample was dropped on a full FIFO
//   stuck_o      : sticky, upstream LFSR declared stuck
module lfsr_rng_buffer
   import lfsr_rng_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            lfsr_state_i,
   input  logic                   enable_i,
   input  logic                   clear_i,
   lfsr_rng_buffer_if.master      bus,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   overflow_o,
   output logic                   stuck_o
);
   localparam int                CNT_W   = 4;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STUCK_LIMIT - 1);

   state_e              state_q, state_d;
   logic [31:0]         prev_q, prev_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                overflow_q, overflow_d;
   logic                stuck_q, stuck_d;

   logic                run_s, same_s, stuck_fire_s, push_s, pop_s;
   logic                full_s, empty_s;
   logic [CNT_W-1:0]    cnt_inc_s;
   logic [SAMPLE_W-1:0] sample_s;

   // Sampling, stuck detection and push/pop qualification.
   always_comb begin
      run_s    = (state_q == ST_RUN);
      same_s   = (lfsr_state_i == prev_q);
      sample_s = sample_byte(lfsr_state_i[7:0], lfsr_state_i[23:16]);
      if (cnt_q == CNT_MAX) begin
         cnt_inc_s = cnt_q;
      end else begin
         cnt_inc_s = cnt_q + CNT_W'(1'b1);
      end
      // Fires on the STUCK_LIMIT-th identical state in a row, so the
      // offending sample itself is never pushed.
      stuck_fire_s = run_s && !clear_i &&
                     ((lfsr_state_i == 32'h0000_0000) || (same_s && (cnt_inc_s == CNT_MAX)));
      push_s       = run_s && enable_i && !stuck_fire_s && !clear_i;
      pop_s        = bus.rd_ready && !empty_s && !clear_i;
   end

   // FSM, stuck counter and sticky flag next-state.
   always_comb begin
      state_d    = state_q;
      prev_d     = lfsr_state_i;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      stuck_d    = stuck_q;
      if (clear_i) begin
         state_d    = ST_IDLE;
         cnt_d      = {CNT_W{1'b0}};
         overflow_d = 1'b0;
         stuck_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (stuck_fire_s) begin
                  state_d = ST_HALT;
               end else if (!enable_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
         if (run_s && same_s) begin
            cnt_d = cnt_inc_s;
         end else begin
            cnt_d = {CNT_W{1'b0}};
         end
         // Full implies non-empty, so a pop frees exactly the slot being pushed.
         overflow_d = overflow_q | (push_s && full_s && !pop_s);
         stuck_d    = stuck_q | stuck_fire_s;
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         prev_q     <= 32'h0000_0000;
         cnt_q      <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         stuck_q    <= stuck_d;
      end
   end

   rng_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear_i),
      .push_i  (push_s),
      .data_i  (sample_s),
      .pop_i   (pop_s),
      .data_o  (bus.rd_data),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_o)
   );

   assign bus.rd_valid = !empty_s;
   assign overflow_o   = overflow_q;
   assign stuck_o      = stuck_q;

endmodule

// File: tb/tb_lfsr_rng_buffer.sv
// tb_lfsr_rng_buffer
//   Directed, table-driven bench for lfsr_rng_buffer (DEPTH=8, STUCK_LIMIT=4)
//   plus a hand-written asynchronous reset sequence.
module tb_lfsr_rng_buffer;

   typedef struct {
      logic        en;
      logic        clr;
      logic        rdy;
      logic [31:0] st;
      logic        ev;
      logic [7:0]  ed;
      logic [3:0]  ec;
      logic        eo;
      logic        es;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [31:0] lfsr;
   logic [3:0]  count;
   logic        ovf;
   logic        stuck;
   int          n_tests;
   int          n_fail;
   vec_t        tbl[$];

   lfsr_rng_buffer_if bus ();

   lfsr_rng_buffer #(.DEPTH(8), .STUCK_LIMIT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lfsr_state_i (lfsr),
      .enable_i     (enable),
      .clear_i      (clear),
      .bus          (bus),
      .count_o      (count),
      .overflow_o   (ovf),
      .stuck_o      (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic en, input logic clr, input logic rdy, input logic [31:0] st,
                      input logic ev, input logic [7:0] ed, input logic [3:0] ec,
                      input logic eo, input logic es);
      vec_t v;
      v.en = en; v.clr = clr; v.rdy = rdy; v.st = st;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.es = es;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      logic [7:0] drain [8];
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      enable  = 1'b0;
      clear   = 1'b0;
      lfsr    = 32'h0;
      bus.rd_ready = 1'b0;

      // ---------------- vector table ----------------
      // Single push, latency 1, sample 0x3C ^ 0xA5 = 0x99
      add(1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // IDLE->RUN
      add(1'b1, 1'b0, 1'b0, 32'h00A5_003C, 1'b1, 8'h99, 4'd1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 8'h99, 4'd1, 1'b0, 1'b0); // RUN->IDLE, data held
      add(1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // pop
      // Fill 8 and overflow on the 9th; samples 0xF0 ^ k
      add(1'b1, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // IDLE->RUN
      for (int k = 1; k <= 9; k++)
         add(1'b1, 1'b0, 1'b0, 32'h00F0_0000 + k, 1'b1, 8'hF1,
             (k <= 8) ? 4'(k) : 4'd8, (k == 9), 1'b0);
      // Full with simultaneous pop: count stays 8, overflow unaffected
      for (int k = 0; k < 5; k++)
         add(1'b1, 1'b0, 1'b1, 32'h00F0_000A + k, 1'b1, 8'hF2 + 8'(k), 4'd8, 1'b1, 1'b0);
      // Drain: push order F6 F7 F8 FA FB FC FD FE (F6 popped by first drain pop)
      drain = '{8'hF7, 8'hF8, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'h00};
      for (int k = 0; k < 8; k++)
         add(1'b0, 1'b0, 1'b1, 32'h0000_0101 + k, (k < 7), drain[k], 4'(7 - k), 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0); // pop on empty
      // Stuck by repetition: 0x78 ^ 0x34 = 0x4C
      add(1'b0, 1'b1, 1'b0, 32'h0000_0201, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // clear
      add(1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // IDLE->RUN
      add(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 8'h4C, 4'd1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 8'h4C, 4'd2, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 8'h4C, 4'd3, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 8'h4C, 4'd3, 1'b0, 1'b1); // 4th: stuck, no push
      add(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 8'h4C, 4'd3, 1'b0, 1'b1); // HALT
      add(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 8'h4C, 4'd3, 1'b0, 1'b1); // HALT, no push
      add(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h4C, 4'd2, 1'b0, 1'b1); // readable in HALT
      add(1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // clear wins
      add(1'b1, 1'b0, 1'b0, 32'h0000_0055, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // IDLE->RUN
      // Zero state: stuck on same edge, sample not pushed
      add(1'b1, 1'b0, 1'b0, 32'h0000_0155, 1'b1, 8'h55, 4'd1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h55, 4'd1, 1'b0, 1'b1);
      // Full + pop from a clean overflow flag
      add(1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // clear
      add(1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); // IDLE->RUN
      for (int k = 0; k < 8; k++)
         add(1'b1, 1'b0, 1'b0, 32'h00F0_0020 + k, 1'b1, 8'hD0, 4'(k + 1), 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 32'h00F0_0028, 1'b1, 8'hD1, 4'd8, 1'b0, 1'b0);

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk("rst_valid", 0, 32'(bus.rd_valid), 32'h0);
      chk("rst_data", 0, 32'(bus.rd_data), 32'h0);
      chk("rst_count", 0, 32'(count), 32'h0);
      chk("rst_ovf", 0, 32'(ovf), 32'h0);
      chk("rst_stuck", 0, 32'(stuck), 32'h0);
      rst_n = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         enable       = tbl[i].en;
         clear        = tbl[i].clr;
         bus.rd_ready = tbl[i].rdy;
         lfsr         = tbl[i].st;
         @(posedge clk);
         #1;
         chk("valid", i, 32'(bus.rd_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk("data", i, 32'(bus.rd_data), 32'(tbl[i].ed));
         chk("count", i, 32'(count), 32'(tbl[i].ec));
         chk("ovf", i, 32'(ovf), 32'(tbl[i].eo));
         chk("stuck", i, 32'(stuck), 32'(tbl[i].es));
      end

      // ---------------- async reset with 5 bytes stored ----------------
      @(negedge clk);
      enable = 1'b0; clear = 1'b1; bus.rd_ready = 1'b0; lfsr = 32'h0000_0400;
      @(negedge clk);
      clear = 1'b0; enable = 1'b1; lfsr = 32'hAAAA_AAAA;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         lfsr = 32'h00F0_0030 + k;
      end
      @(posedge clk);
      #1;
      chk("pre_rst_count", 0, 32'(count), 32'd5);
      chk("pre_rst_data", 0, 32'(bus.rd_data), 32'hC0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 0, 32'(bus.rd_valid), 32'h0);
      chk("arst_data", 0, 32'(bus.rd_data), 32'h0);
      chk("arst_count", 0, 32'(count), 32'h0);
      chk("arst_ovf", 0, 32'(ovf), 32'h0);
      chk("arst_stuck", 0, 32'(stuck), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1; lfsr = 32'h0000_0077;
      @(posedge clk);
      #1;
      chk("post_rst_edge1_count", 0, 32'(count), 32'h0);
      @(negedge clk);
      lfsr = 32'h0000_0177;
      @(posedge clk);
      #1;
      chk("post_rst_edge2_count", 0, 32'(count), 32'd1);
      chk("post_rst_edge2_data", 0, 32'(bus.rd_data), 32'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
